apb_uart_rx: RTL and testbench
==============================

// Module: apb_uart_rx
// PURPOSE
//  APB slave UART receiver: the receive-side companion of the APB UART transmitter peripheral.
//  Samples a serial rx line (8N1, LSB first) and pushes complete bytes into a small RX FIFO.
//  The FIFO and error flags are exposed to the cores over the shared APB slave bus.
//  Sits on one M_PSELx slot of apb_intercon_s and is driven by the SoC rx pin.
// PARAMETERS
//  BUS_WIDTH     16   APB data/address width
//  CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); must be >= 4
//  FIFO_DEPTH    4    RX FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1          system clock; all logic is on the rising edge
//  reset      in   1          asynchronous, active-low reset (0 = reset)
//  S_PADDR    in   BUS_WIDTH  APB address; only bit 0 is decoded (0 = DATA, 1 = STATUS)
//  S_PWRITE   in   1          APB write enable
//  S_PSELx    in   1          APB select for this slave
//  S_PENABLE  in   1          APB access phase
//  S_PWDATA   in   BUS_WIDTH  APB write data
//  S_PRDATA   out  BUS_WIDTH  APB read data; 0 when not selected
//  S_PREADY   out  1          APB ready; 0 when not selected
//  rx_wire    in   1          serial input; idle high
//  rx_irq     out  1          high while FIFO is non-empty
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FSM goes to IDLE and the FIFO is emptied.
//   - OVR and FERR are cleared; rx_irq = 0.
//   - Synchroniser flops reset to 1.
//  Input path: rx_wire passes a 2-flop synchroniser (rxs); all sampling uses rxs.
//  APB:
//   - Zero wait state: S_PREADY = S_PSELx & S_PENABLE (combinational).
//   - S_PRDATA is combinational while S_PSELx = 1; 0 otherwise.
//  Registers:
//   - DATA (read, addr 0): {zeros, head byte}. Reads 0 when the FIFO is empty.
//   - A DATA read pops exactly once per transfer, in the access-phase cycle.
//   - An empty DATA read does not pop. Writes to DATA are ignored.
//   - STATUS (addr 1): bit0 NE (FIFO not empty), bit1 FULL, bit2 OVR, bit3 FERR; other bits read 0.
//   - STATUS writes are write-1-to-clear for bits 2 and 3; all other bits are ignored.
//  FSM states: IDLE, START, DATA, STOP, BREAK. The counter counts clk cycles.
//   - IDLE: rxs = 0 -> START, counter = 0.
//   - START: at count CLKS_PER_BIT/2 (integer division):
//     - rxs = 1 -> IDLE (glitch rejected, nothing recorded).
//     - rxs = 0 -> DATA, counter = 0, bit index = 0.
//   - DATA: every CLKS_PER_BIT cycles, sample rxs into shift[idx], LSB first.
//     After bit 7 -> STOP.
//   - STOP: sample once after CLKS_PER_BIT cycles.
//     - rxs = 1 -> push byte, then IDLE.
//     - rxs = 0 -> set FERR, discard byte, then BREAK.
//   - BREAK: wait for rxs = 1 -> IDLE (a held-low line does not retrigger).
//  Latency: byte is visible in NE on the cycle after the stop-bit sample.
//  FIFO:
//   - Push when full and no pop in the same cycle: byte dropped, OVR set; contents unchanged.
//   - Push and pop in the same cycle: both succeed, including when full (no OVR); count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; the count is held in clog2(FIFO_DEPTH)+1 bits.
//  Flag set/clear races: a hardware set in the same cycle as a W1C clear -> set wins.
//  Reset mid-frame: the frame is abandoned; after release, a new frame needs a fresh falling edge.
// TESTING (bench uses CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
//  1. Frame 0xA5 with a valid stop bit.
//     -> rx_irq = 1; STATUS = 0x0001; DATA read = 0x00A5.
//     -> after the read: STATUS = 0x0000, rx_irq = 0.
//  2. rxs low for 5 cycles, then high (glitch).
//     -> FSM returns to IDLE; FIFO is empty; STATUS = 0x0000.
//  3. Five frames 0x01..0x05, no reads.
//     -> STATUS = 0x0007 (NE|FULL|OVR).
//     -> DATA reads return 0x01, 0x02, 0x03, 0x04, then 0x0000.
//  4. Frame 0x3C with stop bit = 0, line held low for 40 cycles, then high.
//     -> STATUS = 0x0008; no push; no spurious frame.
//     -> write 0x0008 to STATUS -> STATUS reads 0x0000.
//  5. FIFO full, and a DATA read lands in the same cycle as the 5th stop-bit sample.
//     -> count stays 4; OVR = 0; the 5th byte is readable last.
//  6. Assert reset (drive low) at the middle of bit 3 of a frame.
//     -> outputs return to reset values; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/apb_uart_rx.sv
// APB slave UART receiver: 8N1 serial input, LSB first, into a small RX FIFO.
// DATA (addr 0) pops the FIFO head on read. STATUS (addr 1) holds NE/FULL/OVR/FERR; OVR and FERR are write-1-to-clear.
module apb_uart_rx #(
    parameter int BUS_WIDTH    = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
    input  logic                 rx_wire,
    output logic                 rx_irq
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // rx synchroniser
    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_wire};
        end
    end

    assign rxs = sync_q[1];

    // receive FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             ferr_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                // a held-low line must go high before the next frame can start
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // APB decode
    logic data_rd;
    logic status_wr;
    logic pop;
    logic push_ok;
    logic ovr_set;

    assign S_PREADY  = S_PSELx & S_PENABLE;
    assign data_rd   = S_PSELx & S_PENABLE & ~S_PWRITE & ~S_PADDR[0];
    assign status_wr = S_PSELx & S_PENABLE & S_PWRITE & S_PADDR[0];

    // RX FIFO
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ne;
    logic               full;

    assign ne   = (count_q != '0);
    assign full = (count_q == FULL_CNT);
    assign pop  = data_rd & ne;
    // a simultaneous pop frees a slot, so a push into a full FIFO still lands
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // sticky error flags: hardware set wins over a same-cycle clear
    logic ovr_q, ovr_d;
    logic ferr_q, ferr_d;

    always_comb begin
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (status_wr && S_PWDATA[2]) begin
            ovr_d = 1'b0;
        end
        if (status_wr && S_PWDATA[3]) begin
            ferr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
        end
    end

    // read mux
    always_comb begin
        S_PRDATA = '0;
        if (S_PSELx) begin
            if (S_PADDR[0]) begin
                S_PRDATA[3:0] = {ferr_q, ovr_q, full, ne};
            end else if (ne) begin
                S_PRDATA[7:0] = mem_q[rd_ptr_q];
            end
        end
    end

    assign rx_irq = ne;

    logic unused_bits;
    assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed bench for apb_uart_rx: serial frames are driven onto rx_wire and the results are checked through APB reads.
// It uses CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
module tb_apb_uart_rx;

    localparam int BW    = 16;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] S_PADDR;
    logic          S_PWRITE;
    logic          S_PSELx;
    logic          S_PENABLE;
    logic [BW-1:0] S_PWDATA;
    logic [BW-1:0] S_PRDATA;
    logic          S_PREADY;
    logic          rx_wire;
    logic          rx_irq;

    int n_cmp = 0;
    int n_err = 0;

    apb_uart_rx #(
        .BUS_WIDTH   (BW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .S_PADDR  (S_PADDR),
        .S_PWRITE (S_PWRITE),
        .S_PSELx  (S_PSELx),
        .S_PENABLE(S_PENABLE),
        .S_PWDATA (S_PWDATA),
        .S_PRDATA (S_PRDATA),
        .S_PREADY (S_PREADY),
        .rx_wire  (rx_wire),
        .rx_irq   (rx_irq)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        rx_wire = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_wire = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_wire = stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic apb_read(input logic addr, output logic [BW-1:0] data, output logic rdy);
        @(posedge clk);
        #1;
        S_PSELx   = 1'b1;
        S_PADDR   = {{(BW-1){1'b0}}, addr};
        S_PWRITE  = 1'b0;
        S_PENABLE = 1'b0;
        @(posedge clk);
        #1;
        S_PENABLE = 1'b1;
        @(negedge clk);
        data = S_PRDATA;
        rdy  = S_PREADY;
        @(posedge clk);
        #1;
        S_PSELx   = 1'b0;
        S_PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic addr, input logic [BW-1:0] data);
        @(posedge clk);
        #1;
        S_PSELx   = 1'b1;
        S_PADDR   = {{(BW-1){1'b0}}, addr};
        S_PWRITE  = 1'b1;
        S_PWDATA  = data;
        S_PENABLE = 1'b0;
        @(posedge clk);
        #1;
        S_PENABLE = 1'b1;
        @(posedge clk);
        #1;
        S_PSELx   = 1'b0;
        S_PENABLE = 1'b0;
        S_PWRITE  = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        logic [BW-1:0] d;
        logic          r;
        reset     = 1'b0;
        rx_wire   = 1'b1;
        S_PADDR   = '0;
        S_PWRITE  = 1'b0;
        S_PSELx   = 1'b0;
        S_PENABLE = 1'b0;
        S_PWDATA  = '0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected 0", rx_irq);
        end
        n_cmp++;
        if (S_PREADY !== 1'b0 || S_PRDATA !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_unselected: pready %b prdata %h expected 0 / 0000", S_PREADY, S_PRDATA);
        end
        reset = 1'b1;
        idle(4);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0000 || r !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status: got %h ready %b expected 0000 ready 1", d, r);
        end
    endtask

    task automatic test_single_frame();
        logic [BW-1:0] d;
        logic          r;
        send_frame(8'hA5, 1'b1);
        idle(4);
        n_cmp++;
        if (rx_irq !== 1'b1) begin
            n_err++;
            $display("FAIL frame_irq: got %b expected 1", rx_irq);
        end
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0001) begin
            n_err++;
            $display("FAIL frame_status: got %h expected 0001", d);
        end
        apb_write(1'b0, 16'h00FF);
        apb_read(1'b0, d, r);
        n_cmp++;
        if (d !== 16'h00A5) begin
            n_err++;
            $display("FAIL frame_data: got %h expected 00a5", d);
        end
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0000 || rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL frame_after_read: status %h irq %b expected 0000 / 0", d, rx_irq);
        end
    endtask

    task automatic test_glitch();
        logic [BW-1:0] d;
        logic          r;
        @(posedge clk);
        #1;
        rx_wire = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_wire = 1'b1;
        idle(200);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0000 || rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_status: status %h irq %b expected 0000 / 0", d, rx_irq);
        end
        send_frame(8'h33, 1'b1);
        idle(4);
        apb_read(1'b0, d, r);
        n_cmp++;
        if (d !== 16'h0033) begin
            n_err++;
            $display("FAIL glitch_recover: got %h expected 0033", d);
        end
    endtask

    task automatic test_overrun();
        logic [BW-1:0] d;
        logic          r;
        logic [BW-1:0] exp_q[$];
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
        end
        exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000};
        idle(4);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0007) begin
            n_err++;
            $display("FAIL ovr_status: got %h expected 0007", d);
        end
        while (exp_q.size() > 0) begin
            logic [BW-1:0] e;
            e = exp_q.pop_front();
            apb_read(1'b0, d, r);
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL ovr_drain: got %h expected %h", d, e);
            end
        end
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0004) begin
            n_err++;
            $display("FAIL ovr_sticky: got %h expected 0004", d);
        end
        apb_write(1'b1, 16'h0004);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL ovr_clear: got %h expected 0000", d);
        end
    endtask

    task automatic test_framing_error();
        logic [BW-1:0] d;
        logic          r;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        rx_wire = 1'b1;
        idle(200);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0008 || rx_irq !== 1'b0) begin
            n_err++;
            $display("FAIL ferr_status: status %h irq %b expected 0008 / 0", d, rx_irq);
        end
        apb_write(1'b1, 16'h0008);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL ferr_clear: got %h expected 0000", d);
        end
        apb_read(1'b0, d, r);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL ferr_no_push: got %h expected 0000", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic [BW-1:0] d;
        logic [BW-1:0] d_race;
        logic          r;
        logic [BW-1:0] exp_q[$];
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1);
        end
        idle(4);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0003) begin
            n_err++;
            $display("FAIL race_prefill: got %h expected 0003", d);
        end
        // the stop bit of the 5th frame is sampled 156 edges after its start-bit edge
        fork
            send_frame(8'h05, 1'b1);
            begin
                @(posedge clk);
                repeat (153) @(posedge clk);
                apb_read(1'b0, d_race, r);
            end
        join
        n_cmp++;
        if (d_race !== 16'h0001) begin
            n_err++;
            $display("FAIL race_read: got %h expected 0001", d_race);
        end
        idle(4);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0003) begin
            n_err++;
            $display("FAIL race_status: got %h expected 0003", d);
        end
        exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0000};
        while (exp_q.size() > 0) begin
            logic [BW-1:0] e;
            e = exp_q.pop_front();
            apb_read(1'b0, d, r);
            n_cmp++;
            if (d !== e) begin
                n_err++;
                $display("FAIL race_drain: got %h expected %h", d, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [BW-1:0] d;
        logic          r;
        send_frame(8'h77, 1'b1);
        idle(4);
        n_cmp++;
        if (rx_irq !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_prefill: irq %b expected 1", rx_irq);
        end
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(posedge clk);
                repeat (71) @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (rx_irq !== 1'b0) begin
                    n_err++;
                    $display("FAIL midrst_irq: got %b expected 0", rx_irq);
                end
                repeat (11) @(posedge clk);
                #1;
                reset = 1'b1;
            end
        join
        idle(20);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL midrst_status: got %h expected 0000", d);
        end
        send_frame(8'h5A, 1'b1);
        idle(4);
        apb_read(1'b1, d, r);
        n_cmp++;
        if (d !== 16'h0001) begin
            n_err++;
            $display("FAIL midrst_next_status: got %h expected 0001", d);
        end
        apb_read(1'b0, d, r);
        n_cmp++;
        if (d !== 16'h005A) begin
            n_err++;
            $display("FAIL midrst_next_data: got %h expected 005a", d);
        end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_overrun();
        test_framing_error();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
